// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// The per-entry struct depends on module parameters, so it lives in the top.
package led_seq_pkg;

  typedef enum logic {IDLE, RUN} seq_state_t;

  function automatic logic [31:0] dwell_eff(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// clr restarts the count so a new run gets full-length first ticks.
module tick_prescaler #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Table-driven LED pattern sequencer with per-entry dwell in ticks.
// Entries are registers so reset can clear the whole table.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 5_000_000,
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [N_LED-1:0]   cfg_led,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_last,
  output logic [N_LED-1:0]   led_out,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    logic [N_LED-1:0]   led;
    logic [DWELL_W-1:0] dwell;
    logic               last;
  } entry_t;

  entry_t             tbl [DEPTH];
  entry_t             ld_e;
  seq_state_t         state, state_n;
  logic [N_LED-1:0]   led_q, led_n;
  logic [AW-1:0]      idx_q, idx_n, ld_idx;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic               last_q, last_n;
  logic               done_q, done_n;
  logic               ld, clr, tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= '{led: cfg_led, dwell: cfg_dwell, last: cfg_last};
    end
  end

  // Loads read the pre-edge table, so a same-cycle write is not seen.
  assign ld_e = tbl[ld_idx];

  always_comb begin
    state_n = state;
    led_n   = led_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    last_n  = last_q;
    done_n  = 1'b0;
    clr     = 1'b0;
    ld      = 1'b0;
    ld_idx  = '0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          ld      = 1'b1;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tick) begin
          if (cnt_q > DWELL_W'(1)) begin
            cnt_n = cnt_q - DWELL_W'(1);
          end else if (!last_q && idx_q != AW'(DEPTH - 1)) begin
            ld     = 1'b1;
            ld_idx = idx_q + AW'(1);
          end else if (loop_en) begin
            ld = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
    if (ld) begin
      led_n  = ld_e.led;
      idx_n  = ld_idx;
      cnt_n  = DWELL_W'(dwell_eff(32'(ld_e.dwell)));
      last_n = ld_e.last;
    end
    if (state_n == IDLE) begin
      led_n  = '0;
      idx_n  = '0;
      cnt_n  = '0;
      last_n = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      led_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      led_q  <= led_n;
      idx_q  <= idx_n;
      cnt_q  <= cnt_n;
      last_q <= last_n;
      done_q <= done_n;
    end
  end

  assign led_out  = led_q;
  assign step_idx = idx_q;
  assign busy     = (state == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_led_pattern_sequencer;

  logic       clk_in, rst;
  logic       start, stop, loop_en;
  logic       cfg_we, cfg_last;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_led, cfg_dwell;
  logic [3:0] led_out;
  logic [1:0] step_idx;
  logic       busy, done;

  int total = 0;
  int bad   = 0;

  led_pattern_sequencer #(
    .N_LED(4), .TICK_DIV(4), .DEPTH(4), .DWELL_W(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop),
    .loop_en(loop_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_led(cfg_led), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
    .led_out(led_out), .step_idx(step_idx), .busy(busy), .done(done)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic wr(input logic [1:0] a, input logic [3:0] l,
                    input logic [3:0] d, input logic lst);
    cfg_we = 1'b1; cfg_addr = a; cfg_led = l;
    cfg_dwell = d; cfg_last = lst;
    @(negedge clk_in);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    @(negedge clk_in);
    if ({led_out, step_idx, busy, done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold got=%h want=00",
               {led_out, step_idx, busy, done});
    end
    total++;
    rst = 1'b0;
    @(negedge clk_in);
    if ({led_out, step_idx, busy, done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_rel got=%h want=00",
               {led_out, step_idx, busy, done});
    end
    total++;
  endtask

  task automatic test_basic;
    logic [3:0] el;
    logic [1:0] ei;
    wr(2'd0, 4'h1, 4'd1, 1'b0);
    wr(2'd1, 4'h2, 4'd2, 1'b0);
    wr(2'd2, 4'h4, 4'd1, 1'b1);
    start = 1'b1; loop_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      el = i < 4 ? 4'h1 : i < 12 ? 4'h2 : i < 16 ? 4'h4 : 4'h0;
      ei = i < 4 ? 2'd0 : i < 12 ? 2'd1 : i < 16 ? 2'd2 : 2'd0;
      if ({led_out, step_idx} !== {el, ei}) begin
        bad++;
        $display("FAIL basic_led[%0d] got=%h/%0d want=%h/%0d",
                 i, led_out, step_idx, el, ei);
      end
      total++;
      if ({busy, done} !== {i < 16, i == 16}) begin
        bad++;
        $display("FAIL basic_ctl[%0d] got=%b%b want=%b%b",
                 i, busy, done, i < 16, i == 16);
      end
      total++;
    end
  endtask

  task automatic test_loop;
    logic [3:0] el;
    int p;
    start = 1'b1; loop_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      p = i % 16;
      el = i >= 48 ? 4'h0 : p < 4 ? 4'h1 : p < 12 ? 4'h2 : 4'h4;
      if (led_out !== el) begin
        bad++;
        $display("FAIL loop_led[%0d] got=%h want=%h", i, led_out, el);
      end
      total++;
      if ({busy, done} !== {i < 48, i == 48}) begin
        bad++;
        $display("FAIL loop_ctl[%0d] got=%b%b want=%b%b",
                 i, busy, done, i < 48, i == 48);
      end
      total++;
      if (i == 44) loop_en = 1'b0;
    end
  endtask

  task automatic test_zero_dwell;
    logic [3:0] pat [4];
    logic [3:0] el;
    pat[0] = 4'h3; pat[1] = 4'h5; pat[2] = 4'h9; pat[3] = 4'h6;
    for (int k = 0; k < 4; k++) wr(2'(k), pat[k], 4'd0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      el = i < 16 ? pat[i / 4] : i == 17 ? 4'h3 : 4'h0;
      if (led_out !== el) begin
        bad++;
        $display("FAIL zero_led[%0d] got=%h want=%h", i, led_out, el);
      end
      total++;
      if ({busy, done} !== {i != 16, i == 16}) begin
        bad++;
        $display("FAIL zero_ctl[%0d] got=%b%b want=%b%b",
                 i, busy, done, i != 16, i == 16);
      end
      total++;
      if (i < 16 && step_idx !== 2'(i / 4)) begin
        bad++;
        $display("FAIL zero_idx[%0d] got=%0d want=%0d",
                 i, step_idx, i / 4);
      end
      total++;
      // Restart on the done cycle; the run begins one edge later.
      if (i == 16) start = 1'b1;
    end
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_stop got=%b want=0", busy);
    end
    total++;
  endtask

  task automatic test_stop_priority;
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_in);
      if (i < 8) start = 1'b0;
      if (i == 7) begin
        stop = 1'b1; start = 1'b1;
      end
      if (i == 8) begin
        stop = 1'b0; start = 1'b0;
      end
      if (i >= 8 && {led_out, step_idx, busy} !== 7'h00) begin
        bad++;
        $display("FAIL stop_idle[%0d] got=%h/%0d/%b want=0/0/0",
                 i, led_out, step_idx, busy);
      end
      if (i >= 8) total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL stop_done[%0d] got=%b want=0", i, done);
      end
      total++;
    end
  endtask

  task automatic test_live_cfg;
    logic [3:0] el;
    start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      el = i < 4 ? 4'h3 : i < 8 ? 4'h8 : i < 12 ? 4'h9
         : i < 16 ? 4'h6 : 4'h0;
      if (led_out !== el) begin
        bad++;
        $display("FAIL live_led[%0d] got=%h want=%h", i, led_out, el);
      end
      total++;
      cfg_we = 1'b0;
      if (i == 1) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_led = 4'hF;
        cfg_dwell = 4'd0; cfg_last = 1'b0;
      end
      if (i == 2) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_led = 4'h8;
        cfg_dwell = 4'd0; cfg_last = 1'b0;
      end
    end
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL live_done got=%b want=1", done);
    end
    total++;
  endtask

  task automatic test_async_reset;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      start = 1'b0;
    end
    if (led_out !== 4'h8) begin
      bad++;
      $display("FAIL arst_pre got=%h want=8", led_out);
    end
    total++;
    #2 rst = 1'b1;
    #1;
    if ({led_out, step_idx, busy, done} !== 8'h00) begin
      bad++;
      $display("FAIL arst_now got=%h want=00",
               {led_out, step_idx, busy, done});
    end
    total++;
    @(negedge clk_in);
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      if ({led_out, busy, done} !== {4'h0, i < 16, i == 16}) begin
        bad++;
        $display("FAIL arst_run[%0d] got=%h/%b%b want=0/%b%b",
                 i, led_out, busy, done, i < 16, i == 16);
      end
      total++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_led = '0;
    cfg_dwell = '0; cfg_last = 1'b0;
    test_reset();
    test_basic();
    test_loop();
    test_zero_dwell();
    test_stop_priority();
    test_live_cfg();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
